// File: rtl/lut_cfg_writer.sv
// Runtime-writable bank of 4-input LUTs: serial (LSB-first) staging, atomic commit, combinational lookup.
// Latency: accept at edge N, new table visible and done/err pulse from edge N+17; ready again after commit.
// Backpressure: cfg_ready only in IDLE, cfg_valid ignored while busy (no queueing). Optional LUT_CFG_PARITY_EN.
module lut_cfg_writer #(
    parameter int          NUM_LUTS = 4,
    parameter int          SLOT_W   = 2,
    parameter logic [15:0] INIT     = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [15:0]       cfg_data,
`ifdef LUT_CFG_PARITY_EN
    input  logic              cfg_parity,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [SLOT_W-1:0] lut_sel,
    input  logic              a,
    input  logic              b,
    input  logic              c,
    input  logic              d,
    output logic              o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [SLOT_W:0] NUM_LUTS_W = (SLOT_W+1)'(NUM_LUTS);

    state_t            state_q;
    state_t            state_d;
    logic [15:0]       data_sr;
    logic [15:0]       staging;
    logic [3:0]        bit_cnt;
    logic [SLOT_W-1:0] slot_q;
    logic              reject_q;
    logic [15:0]       slots [NUM_LUTS];
    logic              accept;
    logic              commit;
    logic              slot_bad;
    logic              parity_bad;

    assign slot_bad = {1'b0, cfg_slot} >= NUM_LUTS_W;

`ifdef LUT_CFG_PARITY_EN
    assign parity_bad = cfg_parity != ^cfg_data;
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == 4'd15) state_d = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = ~cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bit_cnt  <= 4'd0;
            staging  <= 16'd0;
            data_sr  <= 16'd0;
            slot_q   <= '0;
            reject_q <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= commit & ~reject_q;
            err     <= commit & reject_q;
            if (accept) begin
                data_sr  <= cfg_data;
                slot_q   <= cfg_slot;
                reject_q <= slot_bad | parity_bad;
                bit_cnt  <= 4'd0;
            end else if (state_q == SHIFT) begin
                // bit 0 enters at the top and reaches staging[0] after 16 shifts
                staging <= {data_sr[0], staging[15:1]};
                data_sr <= {1'b0, data_sr[15:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Only the whole staged word is ever written, so lookups never see a partial table
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (rst) begin
                slots[i] <= INIT;
            end else if (commit && !reject_q && slot_q == SLOT_W'(i)) begin
                slots[i] <= staging;
            end
        end
    end

    always_comb begin
        o = 1'b0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (lut_sel == SLOT_W'(i)) o = slots[i][{d, c, b, a}];
        end
    end

endmodule

// File: tb/tb_lut_cfg_writer.sv
// Bench for lut_cfg_writer (3-slot bank, non-zero INIT): table vectors, timed load sequences, random soak.
module tb_lut_cfg_writer;
    localparam int          NL     = 3;
    localparam int          SW     = 2;
    localparam logic [15:0] INIT_V = 16'h6A5C;
`ifdef LUT_CFG_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [SW-1:0] cfg_slot;
    logic [15:0]   cfg_data;
`ifdef LUT_CFG_PARITY_EN
    logic          cfg_parity;
`endif
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] lut_sel;
    logic          a, b, c, d;
    logic          o;

    always #5 clk = ~clk;

    lut_cfg_writer #(.NUM_LUTS(NL), .SLOT_W(SW), .INIT(INIT_V)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_slot  (cfg_slot),
        .cfg_data  (cfg_data),
`ifdef LUT_CFG_PARITY_EN
        .cfg_parity(cfg_parity),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .lut_sel   (lut_sel),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .o         (o)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl [4];

    typedef struct {
        int         phase;
        logic [1:0] sel;
        logic [3:0] idx;
        logic       exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_o(input logic [1:0] sel, input logic [3:0] idx);
        logic [15:0] t;
        if (int'(sel) >= NL) return 1'b0;
        t = mdl[sel];
        return t[idx];
    endfunction

    task automatic look(input logic [1:0] sel, input logic [3:0] idx);
        lut_sel = sel;
        {d, c, b, a} = idx;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mdl[i] = INIT_V;
    endtask

    task automatic sweep_all(input string nm);
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) begin
                look(2'(s), 4'(i));
                #1;
                chk(nm, o, model_o(2'(s), 4'(i)));
            end
        end
    endtask

    // One full load: checks ready/busy/done/err every cycle, o each cycle (old table until commit)
    task automatic load(input logic [1:0] slot, input logic [15:0] data, input logic par,
                        input bit sweep, input logic [1:0] ssel);
        logic rej;
        int   w;
        rej = (int'(slot) >= NL) || (PAR_EN && (par != ^data));
        w = 0;
        while (!cfg_ready && w < 40) begin
            tick();
            w++;
        end
        chk("ready_before_accept", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_slot  = slot;
        cfg_data  = data;
`ifdef LUT_CFG_PARITY_EN
        cfg_parity = par;
`endif
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) tick();
            if (k == 17 && !rej) mdl[slot] = data;
            chk("busy", busy, (k != 17));
            chk("ready", cfg_ready, (k == 17));
            chk("done", done, (k == 17 && !rej));
            chk("err", err, (k == 17 && rej));
            cfg_valid = (k < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_slot  = 2'($urandom_range(0, 3));
            cfg_data  = 16'($urandom);
            if (sweep) look(ssel, 4'(k));
            else       look(2'($urandom_range(0, 3)), 4'($urandom));
            #1;
            chk("o_during_load", o, model_o(lut_sel, {d, c, b, a}));
        end
        tick();
        chk("done_pulse_end", done, 0);
        chk("err_pulse_end", err, 0);
    endtask

    logic [15:0] init_v;
    logic [3:0]  iv;
    logic [15:0] rd;
    logic        rp;

    initial begin
        init_v = INIT_V;
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            vecs.push_back('{phase: 1, sel: 2'd0, idx: iv, exp: init_v[i]});
            vecs.push_back('{phase: 2, sel: 2'd1, idx: iv,
                             exp: ((iv[0] & ~iv[1]) ^ iv[2]) | iv[3]});
        end
        vecs.push_back('{phase: 1, sel: 2'd3, idx: 4'hF, exp: 1'b0});
        vecs.push_back('{phase: 2, sel: 2'd3, idx: 4'h5, exp: 1'b0});

        rst = 1'b1; cfg_valid = 1'b0; cfg_slot = '0; cfg_data = '0;
`ifdef LUT_CFG_PARITY_EN
        cfg_parity = 1'b0;
`endif
        look(2'd0, 4'd0);
        model_reset();
        tick();
        tick();
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // 1: INIT table on slot 0
        foreach (vecs[i]) if (vecs[i].phase == 1) begin
            look(vecs[i].sel, vecs[i].idx);
            #1;
            chk("init_table", o, vecs[i].exp);
        end

        // 2: slot 1 becomes ((a&~b)^c)|d
        load(2'd1, 16'hFFD2, ^16'hFFD2, 1'b0, 2'd0);
        foreach (vecs[i]) if (vecs[i].phase == 2) begin
            look(vecs[i].sel, vecs[i].idx);
            #1;
            chk("ffd2_table", o, vecs[i].exp);
        end

        // 3: watch slot 2 during its own reload
        load(2'd2, 16'h8000, ^16'h8000, 1'b1, 2'd2);
        sweep_all("after_8000");

        // 4: back-to-back with cfg_valid held high
        cfg_valid = 1'b1; cfg_slot = 2'd0; cfg_data = 16'h1234;
`ifdef LUT_CFG_PARITY_EN
        cfg_parity = ^16'h1234;
`endif
        tick();
        chk("b2b_first_accept", busy, 1);
        cfg_slot = 2'd1; cfg_data = 16'h00FF;
`ifdef LUT_CFG_PARITY_EN
        cfg_parity = ^16'h00FF;
`endif
        for (int k = 1; k <= 17; k++) tick();
        chk("b2b_ready", cfg_ready, 1);
        chk("b2b_done1", done, 1);
        mdl[0] = 16'h1234;
        tick();
        chk("b2b_second_accept", busy, 1);
        chk("b2b_done1_end", done, 0);
        cfg_valid = 1'b0;
        for (int k = 1; k <= 17; k++) tick();
        chk("b2b_done2", done, 1);
        mdl[1] = 16'h00FF;
        sweep_all("after_b2b");

        // 5: reset in the middle of a shift
        cfg_valid = 1'b1; cfg_slot = 2'd0; cfg_data = 16'hAAAA;
`ifdef LUT_CFG_PARITY_EN
        cfg_parity = ^16'hAAAA;
`endif
        tick();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midrst_ready", cfg_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("midrst_no_done", {done, err}, 2'b00);
        end
        sweep_all("after_midrst");

        // 6: rejected words
        load(2'd3, 16'hBEEF, ^16'hBEEF, 1'b0, 2'd0);
        sweep_all("after_badslot");
`ifdef LUT_CFG_PARITY_EN
        load(2'd0, 16'h0001, 1'b0, 1'b0, 2'd0);
        sweep_all("after_badparity");
`endif

        // random soak
        for (int n = 0; n < 250; n++) begin
            rd = 16'($urandom);
            rp = ^rd;
            if (PAR_EN && $urandom_range(0, 3) == 0) rp = ~rp;
            load(2'($urandom_range(0, 3)), rd, rp, 1'b0, 2'd0);
        end
        for (int n = 0; n < 2000; n++) begin
            look(2'($urandom_range(0, 3)), 4'($urandom));
            #1;
            chk("soak_lookup", o, model_o(lut_sel, {d, c, b, a}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
